// File: rtl/window_line_buffer.sv
// Streaming 3x3 window generator: two row line buffers plus a registered p1..p9 window.
// Optional out_eof port (final window of a frame) is enabled by defining WINDOW_EOF_EN.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module window_line_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [`WORD_SIZE-1:0] in_data,
  output logic [`WORD_SIZE-1:0] p1,
  output logic [`WORD_SIZE-1:0] p2,
  output logic [`WORD_SIZE-1:0] p3,
  output logic [`WORD_SIZE-1:0] p4,
  output logic [`WORD_SIZE-1:0] p5,
  output logic [`WORD_SIZE-1:0] p6,
  output logic [`WORD_SIZE-1:0] p7,
  output logic [`WORD_SIZE-1:0] p8,
  output logic [`WORD_SIZE-1:0] p9,
`ifdef WINDOW_EOF_EN
  output logic                  out_eof,
`endif
  output logic                  out_valid,
  output logic [COL_W-1:0]      out_col,
  output logic [ROW_W-1:0]      out_row
);
  localparam int DW = `WORD_SIZE;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [DW-1:0] lb1_q [IMG_WIDTH];
  logic [DW-1:0] lb2_q [IMG_WIDTH];

  logic [8:0][DW-1:0] win_q, win_d;
  logic [COL_W-1:0]   col_q, col_d, col_e, ocol_q, ocol_d;
  logic [ROW_W-1:0]   row_q, row_d, row_e, orow_q, orow_d;
  logic               vld_q, vld_d, win_ok;
  logic [DW-1:0]      lb1_rd, lb2_rd;
  logic               eof_q, eof_d;

  // in_sof forces (0,0) so a mid-frame restart takes effect on that very pixel
  always_comb begin
    col_e  = in_sof ? '0 : col_q;
    row_e  = in_sof ? '0 : row_q;
    lb1_rd = lb1_q[col_e];
    lb2_rd = lb2_q[col_e];
    win_ok = in_valid && (col_e >= COL_W'(2)) && (row_e >= ROW_W'(2));
  end

  always_comb begin
    win_d  = win_q;
    col_d  = col_q;
    row_d  = row_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    vld_d  = win_ok;
    eof_d  = win_ok && (col_e == COL_LAST) && (row_e == ROW_LAST);
    if (in_valid) begin
      win_d = {in_data, win_q[8], win_q[7], lb1_rd, win_q[5], win_q[4],
               lb2_rd, win_q[2], win_q[1]};
      if (col_e == COL_LAST) begin
        col_d = '0;
        row_d = (row_e == ROW_LAST) ? '0 : row_e + ROW_W'(1);
      end else begin
        col_d = col_e + COL_W'(1);
        row_d = row_e;
      end
    end
    if (win_ok) begin
      ocol_d = col_e - COL_W'(1);
      orow_d = row_e - ROW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
      ocol_q <= '0;
      orow_q <= '0;
      vld_q  <= 1'b0;
      eof_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      col_q  <= col_d;
      row_q  <= row_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
      vld_q  <= vld_d;
      eof_q  <= eof_d;
    end
  end

  // Line buffers are deliberately not reset; rows 0-1 refill them before any window is valid
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2_q[col_e] <= lb1_rd;
      lb1_q[col_e] <= in_data;
    end
  end

  assign {p9, p8, p7, p6, p5, p4, p3, p2, p1} = win_q;
  assign out_valid = vld_q;
  assign out_col   = ocol_q;
  assign out_row   = orow_q;
`ifdef WINDOW_EOF_EN
  assign out_eof   = eof_q;
`endif

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Streaming 3x3 window generator that sits directly upstream of the Sobel and thresholding window stages.
- Accepts one raster-order pixel per valid cycle, keeps the two previous image rows in internal line buffers, and presents a registered 3x3 neighbourhood p1..p9 with a valid strobe and the centre-pixel coordinates.
- Downstream window stages consume p1..p9 combinationally.

Parameters:
- IMG_WIDTH, 640, pixels per row; must be >= 3.
- IMG_HEIGHT, 480, rows per frame; must be >= 3.
- COL_W, $clog2(IMG_WIDTH), column counter / coordinate width.
- ROW_W, $clog2(IMG_HEIGHT), row counter / coordinate width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is a valid pixel this cycle (gaps allowed).
- in_sof  input  1  qualified by in_valid: this pixel is row 0, col 0 of a new frame.
- in_data  input  `WORD_SIZE  pixel value.
- p1..p9  output  `WORD_SIZE each  window, row-major (p1 top-left, p5 centre, p9 bottom-right).
- out_valid  output  1  p1..p9 hold a complete in-image window.
- out_col  output  COL_W  column of the centre pixel p5.
- out_row  output  ROW_W  row of the centre pixel p5.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values:
  - p1..p9 = 0, out_valid = 0, out_col = 0, out_row = 0.
  - Column and row counters = 0.
  - Line-buffer contents are not cleared; they are don't-care until row 2 is reached.
- Accept: a pixel is accepted on any cycle with in_valid = 1. No backpressure. When in_valid = 0, all state holds, including outputs.
- Effective position:
  - (col, row) = (0, 0) if in_sof = 1; otherwise the current counters.
  - in_sof mid-frame aborts the current frame immediately; that pixel is treated as (0, 0).
- Line buffers: two IMG_WIDTH-deep arrays, lb1 (previous row) and lb2 (two rows back). On accept at column col:
  - lb2[col] <= lb1[col]
  - lb1[col] <= in_data
  - The reads used by the window use the pre-update values.
- Window shift on accept:
  - p1 <= p2, p2 <= p3, p3 <= lb2[col]
  - p4 <= p5, p5 <= p6, p6 <= lb1[col]
  - p7 <= p8, p8 <= p9, p9 <= in_data
- Valid and coordinates:
  - out_valid <= accept and col >= 2 and row >= 2; otherwise 0.
  - out_valid is a one-cycle strobe per accepted pixel, i.e. latency 1 cycle from the accepting edge.
  - On a valid window, out_col <= col - 1 and out_row <= row - 1. These hold otherwise.
- Row wrap:
  - Windows are suppressed at col 0 and 1 of every row, so stale columns from the previous row are never flagged valid.
  - Border pixels (row/col 0 and last row/col) never appear as centre.
  - Exactly (IMG_WIDTH - 2) * (IMG_HEIGHT - 2) valid windows per frame.
- Counter update on accept:
  - If col == IMG_WIDTH - 1: col <= 0, and row <= (row == IMG_HEIGHT - 1) ? 0 : row + 1.
  - Otherwise col <= col + 1.
  - After the last pixel the block is ready for the next frame with no in_sof required.
- Arithmetic: counters compare against parameters, with no overflow past IMG_WIDTH - 1 / IMG_HEIGHT - 1. Pixel data is passed through unmodified.
- Reset mid-frame: all outputs drop to reset values asynchronously. The next accepted pixel is (0, 0).

Optional Feature:
- Macro: WINDOW_EOF_EN.
- Defined:
  - Adds output port out_eof (1 bit, reset 0).
  - out_eof is asserted together with out_valid for the final window of a frame (centre at col IMG_WIDTH - 2, row IMG_HEIGHT - 2, produced on accepting pixel (IMG_WIDTH - 1, IMG_HEIGHT - 1)).
  - out_eof is 0 on all other cycles.
- Not defined: port absent; behaviour otherwise identical.

Test Plan:
- Basic window. IMG_WIDTH=8, IMG_HEIGHT=6, WORD_SIZE=8; stream pixel value = row*16 + col, continuous in_valid with in_sof on the first pixel. Required response, one cycle after accepting (2,2):
  - out_valid = 1, out_col = 1, out_row = 1.
  - p1..p9 = 00, 01, 02, 10, 11, 12, 20, 21, 22.
- Valid count. Same full frame -> exactly 24 out_valid strobes. None in the cycles following accept of rows 0–1 or cols 0–1. Last strobe has centre (6,4) and p9 = 0x57.
- Gapped input. Same frame with in_valid toggled pseudo-randomly (~50%) -> identical sequence of windows and coordinates; outputs hold during gaps.
- Frame restart. Assert in_sof at pixel (5,3) of frame 1, then stream a new frame with values 0x80 + row*16 + col. Required response:
  - No valid for the first two new rows.
  - First window has centre (1,1) with p5 = 0x91.
- Reset mid-frame. Pulse reset_n low for 3 cycles during row 3 -> all outputs 0 immediately. A fresh frame (no in_sof) yields 24 correct windows.
- With WINDOW_EOF_EN, back-to-back frames -> out_eof high exactly once per frame, coincident with the (6,4) window. Frame 2's first window is correct without in_sof.
